// File: rtl/mod_n_pkg.sv
// Shared types and helpers for the mod_n_counter family.
package mod_n_pkg;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    function automatic int digit_w(int mod);
        return $clog2(mod);
    endfunction

endpackage

// File: rtl/mod_n_stage.sv
// One mod-MOD digit of the cascade: clear/load/step with saturating load
// and a direction-aware terminal flag that also covers illegal values.
module mod_n_stage
    import mod_n_pkg::*;
#(
    parameter int MOD = 3,
    localparam int CW = digit_w(MOD)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          step_i,
    input  dir_e          dir_i,
    output logic [CW-1:0] digit_o,
    output logic          term_o,
    output logic          sat_o
);

    localparam logic [CW-1:0] MAX = CW'(MOD - 1);

    logic [CW-1:0] digit_q, digit_d;
    logic          illegal;

    // Out-of-range values count as terminal so the next step recovers them.
    assign illegal = int'(digit_q) >= MOD;
    assign term_o  = (dir_i == DIR_UP) ? (int'(digit_q) >= MOD - 1)
                                       : ((digit_q == '0) || illegal);
    assign sat_o   = int'(load_val_i) >= MOD;
    assign digit_o = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (clear_i) begin
            digit_d = '0;
        end else if (load_i) begin
            digit_d = sat_o ? MAX : load_val_i;
        end else if (step_i) begin
            if (dir_i == DIR_UP) begin
                digit_d = term_o ? '0 : digit_q + CW'(1);
            end else begin
                digit_d = term_o ? MAX : digit_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/mod_n_cascade_counter.sv
// Synchronous cascade of STAGES mod-MOD digits with up/down count, clear,
// parallel load, combinational terminal count and registered wrap/load-error pulses.
module mod_n_cascade_counter
    import mod_n_pkg::*;
#(
    parameter int MOD    = 3,
    parameter int STAGES = 2,
    localparam int CW    = digit_w(MOD)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 dir_i,
    input  logic                 load_i,
    input  logic [STAGES*CW-1:0] load_val_i,
    output logic [STAGES*CW-1:0] count_o,
    output logic                 tc_o,
    output logic                 wrap_o,
    output logic                 load_err_o
);

    logic [STAGES-1:0] term;
    logic [STAGES-1:0] sat;
    logic [STAGES:0]   carry;
    logic              wrap_q, wrap_d;
    logic              load_err_q, load_err_d;
    dir_e              dir;

    assign dir      = dir_e'(dir_i);
    assign carry[0] = 1'b1;

    // carry[k] is high when every lower digit sits at its terminal value.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        mod_n_stage #(.MOD(MOD)) u_stage (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clear_i    (clear_i),
            .load_i     (load_i),
            .load_val_i (load_val_i[k*CW +: CW]),
            .step_i     (en_i & carry[k]),
            .dir_i      (dir),
            .digit_o    (count_o[k*CW +: CW]),
            .term_o     (term[k]),
            .sat_o      (sat[k])
        );
        assign carry[k+1] = carry[k] & term[k];
    end

    assign tc_o = en_i & carry[STAGES];

    always_comb begin
        wrap_d     = en_i & ~clear_i & ~load_i & carry[STAGES];
        load_err_d = ~clear_i & load_i & (|sat);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign wrap_o     = wrap_q;
    assign load_err_o = load_err_q;

endmodule

// File: doc/mod_n_cascade_counter.md
# mod_n_cascade_counter

Parametrised synchronous successor to the single-stage mod-3 ripple counter: a cascade of `STAGES` mod-`MOD` digits, clocked from one system clock. It supports up/down counting, enable, synchronous clear and parallel load. It also provides a terminal-count flag and a registered wrap pulse for chaining. It sits in the `mod_n_counter` family as the general-purpose counter for prescalers, digit counters and timeout timers.

## Interface
Parameters:
- `MOD`, default 3: modulus of every digit; legal range is 2 or more.
- `STAGES`, default 2: number of cascaded digits; legal range is 1 or more.
- `CW`, derived, not overridable: `$clog2(MOD)`, the width of each digit.

Ports:
- `clk_i`  input  1  system clock; all state changes on its rising edge.
- `rst_ni`  input  1  asynchronous, active-low reset.
- `clear_i`  input  1  synchronous clear of all digits to 0.
- `en_i`  input  1  count enable.
- `dir_i`  input  1  direction: 0 = up, 1 = down.
- `load_i`  input  1  synchronous parallel load.
- `load_val_i`  input  STAGES*CW  load value; digit k occupies bits [k*CW +: CW], and digit 0 is least significant.
- `count_o`  output  STAGES*CW  current count, packed the same way as `load_val_i`.
- `tc_o`  output  1  combinational terminal count. It is 1 when `en_i` is high and every digit is at its terminal value: `MOD-1` when counting up, 0 when counting down.
- `wrap_o`  output  1  registered one-cycle pulse. It is high in the cycle after the whole cascade wrapped.
- `load_err_o`  output  1  registered one-cycle pulse. It is high in the cycle after a load that contained an out-of-range digit.

## Operation
- Reset (`rst_ni` low) asynchronously forces every digit, `wrap_o` and `load_err_o` to 0.
  - `tc_o` follows the reset state: 0 when counting up, and `en_i` when counting down.
- Per-edge priority is `clear_i` > `load_i` > `en_i`. Exactly one action is taken per edge.
- **Clear:** all digits go to 0. `wrap_o` and `load_err_o` are 0 next cycle.
- **Load:** each digit takes its field of `load_val_i`.
  - A field of `MOD` or more saturates to `MOD-1`, and `load_err_o` pulses next cycle.
  - Load never causes `wrap_o`.
- **Count (`en_i` high):** digit 0 always steps.
  - Digit k steps only when digits 0..k-1 are all at terminal in the current direction (ripple-free synchronous carry/borrow).
  - Up: a digit at `MOD-1` becomes 0; otherwise it increments.
  - Down: a digit at 0 becomes `MOD-1`; otherwise it decrements.
  - When every digit is at terminal, the whole cascade wraps: all 0 going up, all `MOD-1` going down. `wrap_o` pulses next cycle.
- **Idle (`en_i` low):** the count holds, and `wrap_o` and `load_err_o` are 0 next cycle.
- **Direction change:** `dir_i` may change on any cycle and takes effect on the next edge; there is no pipeline to flush.
- **Illegal states:** digit values of `MOD` or more are unreachable. If one arises (e.g. via X-injection), the next enabled step treats it as terminal.

## Timing
- Count latency: the new `count_o` is visible one cycle after the sampling edge.
- `tc_o` is combinational from `en_i`, `dir_i` and the digit registers; no combinational path from `load_val_i`.
- `tc_o` high at edge n implies `wrap_o` high during cycle n+1. The exception is when `clear_i` or `load_i` is also high at edge n; then `wrap_o` stays 0.
- Reset deassertion must be synchronised externally to `clk_i`. The first count occurs on the first edge with `rst_ni` high and `en_i` high.
- Reset asserted mid-count zeroes the state immediately, with no clock required. Any pending `wrap_o` or `load_err_o` pulse is discarded.

## Structure
- Package `mod_n_pkg`:
  - `typedef enum logic {DIR_UP, DIR_DOWN} dir_e`
  - function `digit_w(int mod)` returning `$clog2(mod)`
- Sub-module `mod_n_stage`: one digit.
  - Parameter: `MOD`.
  - Inputs: clear, load, load value, step, direction.
  - Outputs: digit value, at-terminal flag, load-saturated flag.
- The top instantiates `STAGES` copies in a generate loop. It ANDs the at-terminal flags to form the carry chain, and registers `wrap_o` and `load_err_o`.

## Test plan
All scenarios use `MOD=3`, `STAGES=2` unless stated.
1. Reset, then `en_i=1`, `dir_i=0` for 10 cycles → digit pairs (d1,d0) run 00,01,02,10,…,22,00. `tc_o` is high at 22, and `wrap_o` pulses exactly once, in the cycle after 22→00.
2. `dir_i=1` from reset → 00→22→21→…. `tc_o` is high at 00, and `wrap_o` pulses after 00→22.
3. `load_i` with d1=3, d0=1 → count becomes 21 and `load_err_o` pulses once. A load with d1=1, d0=2 gives 12 with no error.
4. `clear_i`, `load_i` and `en_i` all high at count 22 → count becomes 00, and neither `wrap_o` nor `load_err_o` pulses.
5. `rst_ni` pulsed low mid-cycle at count 12 with `en_i` held → count goes to 00 immediately, without a clock edge. Counting resumes at 01 on the first edge after release.
6. `MOD=4`, `STAGES=1`, `dir_i` toggled every cycle → count sequence 0,1,0,1,…, and `wrap_o` never pulses.
